// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter: control inputs, load/limit data and
// gated count outputs. The slave modport is the counter; the master drives it.
interface param_updown_counter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
);
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             cnt_en;
    logic             up_dn;
    logic             sat;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic             oe_n;
    logic [WIDTH-1:0] count;
    logic             count_oe;
    logic             tc;

    modport master (
        output ena, load, load_val, cnt_en, up_dn, sat, limit, prescale, oe_n,
        input  count, count_oe, tc
    );

    modport slave (
        input  ena, load, load_val, cnt_en, up_dn, sat, limit, prescale, oe_n,
        output count, count_oe, tc
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with load, wrap/saturate at a programmable
// limit, optional tick prescaler and a registered terminal-count pulse.
// Optional feature macro: PCNT_PRESCALER_EN (prescaler compiled in when defined;
// otherwise every enabled cycle is a tick and the prescale input is unused).
module param_updown_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    param_updown_counter_if.slave  bus
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_tick;
    logic             w_step;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_count_nxt;

`ifdef PCNT_PRESCALER_EN
    logic [PRE_W-1:0] r_pre_cnt;

    assign w_tick = (r_pre_cnt == bus.prescale);

    // Prescaler: free-running divider, restarted by a load or on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (bus.ena) begin
            if (bus.load || w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
        end
    end
`else
    logic w_unused_prescale;

    assign w_tick            = 1'b1;
    assign w_unused_prescale = ^bus.prescale;
`endif

    // A counting step only happens on a tick that is not overridden by load
    assign w_step     = w_tick & bus.cnt_en & ~bus.load;
    assign w_at_bound = bus.up_dn ? (r_count >= bus.limit) : (r_count == '0);

    // Next counter value: load has priority, then boundary-aware up/down step
    always_comb begin
        w_count_nxt = r_count;
        if (bus.load) begin
            w_count_nxt = bus.load_val;
        end else if (w_step) begin
            if (bus.up_dn) begin
                if (!w_at_bound) begin
                    w_count_nxt = r_count + WIDTH'(1);
                end else if (!bus.sat) begin
                    w_count_nxt = '0;
                end
            end else begin
                if (!w_at_bound) begin
                    w_count_nxt = r_count - WIDTH'(1);
                end else if (!bus.sat) begin
                    w_count_nxt = bus.limit;
                end
            end
        end
    end

    // Counter and terminal-count registers; ena=0 freezes both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (bus.ena) begin
            r_count <= w_count_nxt;
            r_tc    <= w_step & w_at_bound;
        end
    end

    assign bus.count    = bus.oe_n ? '0 : r_count;
    assign bus.count_oe = ~bus.oe_n;
    assign bus.tc       = r_tc;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (WIDTH=8, PRE_W=4).
// Inputs change just after a falling edge; outputs are checked on the next
// falling edge, i.e. after exactly one rising edge.
`timescale 1ns/1ps
module tb_param_updown_counter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PRE_W = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fails;

    param_updown_counter_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) u_if ();

    param_updown_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_ct(input string tag, input logic [7:0] c, input logic t);
        check({tag, "_count"}, 32'(u_if.count), 32'(c));
        check({tag, "_tc"},    32'(u_if.tc),    32'(t));
    endtask

    task automatic do_load(input logic [7:0] v);
        u_if.load     = 1'b1;
        u_if.load_val = v;
        step();
        u_if.load     = 1'b0;
    endtask

    logic [7:0] up_exp [6];
    logic       up_tc  [6];
    logic [7:0] pre_exp [8];

    initial begin
        n_tests = 0;
        n_fails = 0;
        up_exp  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        up_tc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef PCNT_PRESCALER_EN
        pre_exp = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
`else
        pre_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
`endif

        rst_n         = 1'b0;
        u_if.ena      = 1'b0;
        u_if.load     = 1'b0;
        u_if.load_val = '0;
        u_if.cnt_en   = 1'b0;
        u_if.up_dn    = 1'b1;
        u_if.sat      = 1'b0;
        u_if.limit    = 8'd5;
        u_if.prescale = '0;
        u_if.oe_n     = 1'b0;

        // Reset state
        step();
        check_ct("reset", 8'h00, 1'b0);
        check("reset_oe", 32'(u_if.count_oe), 32'd1);
        rst_n = 1'b1;

        // Up wrap at limit 5 with tc after the 5->0 step
        u_if.ena    = 1'b1;
        u_if.cnt_en = 1'b1;
        do_load(8'd0);
        check_ct("up_load", 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_ct($sformatf("up_wrap%0d", i), up_exp[i], up_tc[i]);
        end
        step();
        check_ct("up_after_wrap", 8'd1, 1'b0);

        // Down saturate from 2: 1,0,0,0 with tc on each tick at 0
        do_load(8'd2);
        check_ct("dn_load", 8'd2, 1'b0);
        u_if.up_dn = 1'b0;
        u_if.sat   = 1'b1;
        step(); check_ct("dn_sat0", 8'd1, 1'b0);
        step(); check_ct("dn_sat1", 8'd0, 1'b0);
        step(); check_ct("dn_sat2", 8'd0, 1'b1);
        step(); check_ct("dn_sat3", 8'd0, 1'b1);

        // ena=0 freezes count and tc and ignores load
        u_if.ena      = 1'b0;
        u_if.load     = 1'b1;
        u_if.load_val = 8'h55;
        step(); check_ct("ena_off0", 8'd0, 1'b1);
        step(); check_ct("ena_off1", 8'd0, 1'b1);
        u_if.load = 1'b0;
        u_if.ena  = 1'b1;

        // Down wrap from 1 with limit 5: 0, 5 (tc), 4
        u_if.sat = 1'b0;
        do_load(8'd1);
        check_ct("dw_load", 8'd1, 1'b0);
        step(); check_ct("dw0", 8'd0, 1'b0);
        step(); check_ct("dw1", 8'd5, 1'b1);
        step(); check_ct("dw2", 8'd4, 1'b0);

        // cnt_en=0 holds the count
        u_if.cnt_en = 1'b0;
        step(); check_ct("hold0", 8'd4, 1'b0);
        step(); check_ct("hold1", 8'd4, 1'b0);
        u_if.cnt_en = 1'b1;

        // Prescaler divide-by-4 (or every cycle when compiled out)
        u_if.up_dn = 1'b1;
        u_if.limit = 8'hFF;
`ifdef PCNT_PRESCALER_EN
        u_if.prescale = 4'd3;
`else
        u_if.prescale = 4'd7;
`endif
        do_load(8'd0);
        check_ct("pre_load", 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_ct($sformatf("pre%0d", i), pre_exp[i], 1'b0);
        end
        u_if.prescale = '0;

        // Load beats a boundary tick; next up tick wraps above-limit value
        u_if.limit = 8'h10;
        do_load(8'h10);
        check_ct("pri_pre", 8'h10, 1'b0);
        do_load(8'hA0);
        check_ct("pri_load", 8'hA0, 1'b0);
        step(); check_ct("pri_wrap", 8'h00, 1'b1);

        // Above-limit value in saturate mode holds with tc
        u_if.sat = 1'b1;
        do_load(8'hA0);
        step(); check_ct("sat_hold", 8'hA0, 1'b1);
        u_if.sat = 1'b0;

        // Asynchronous reset between edges at 0x37
        u_if.limit  = 8'hFF;
        u_if.cnt_en = 1'b0;
        do_load(8'h37);
        check_ct("rst_pre", 8'h37, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_ct("rst_async", 8'h00, 1'b0);
        #1 rst_n = 1'b1;
        step();
        check_ct("rst_hold", 8'h00, 1'b0);
        u_if.cnt_en = 1'b1;
        step(); check_ct("rst_resume", 8'h01, 1'b0);

        // Output enable gates count without touching internal state
        u_if.cnt_en = 1'b0;
        do_load(8'h37);
        u_if.oe_n = 1'b1;
        #1;
        check("oe_count", 32'(u_if.count), 32'h00);
        check("oe_count_oe", 32'(u_if.count_oe), 32'd0);
        step();
        u_if.oe_n = 1'b0;
        #1;
        check("oe_restore", 32'(u_if.count), 32'h37);
        check("oe_restore_oe", 32'(u_if.count_oe), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
